// File: rtl/fpmult_seq.sv
// Multi-cycle IEEE-754 single-precision multiplier (shift-add mantissa datapath, fixed latency).
// Optional build macro FPMULT_SEQ_RNE_EN selects round-to-nearest-even; otherwise truncation.
module fpmult_seq #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done
);

    localparam int         STEPS    = 24 / BITS_PER_CYCLE;
    localparam logic [4:0] LAST_CNT = 5'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_NORM = 2'd2,
        S_PACK = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [4:0]         r_cnt;
    logic               r_sign;
    logic signed [9:0]  r_exp;
    logic [47:0]        r_mcand;
    logic [23:0]        r_mplier;
    logic [47:0]        r_prod;
    logic [22:0]        r_frac;
    logic               r_nan_any;
    logic               r_inf_any;
    logic               r_zero_any;
    logic [31:0]        r_result;
`ifdef FPMULT_SEQ_RNE_EN
    logic               r_guard;
    logic               r_sticky;
    logic               w_round_up;
    logic [24:0]        w_mant_sum;
`endif

    logic               w_sign;
    logic signed [9:0]  w_exp_sum;
    logic               w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic [23:0]        w_ma, w_mb;
    logic signed [9:0]  w_exp_fin;
    logic [22:0]        w_frac_fin;
    logic [31:0]        w_pack_res;

    // Sum of the multiplicand shifted by each set bit among the low BITS_PER_CYCLE multiplier bits.
    function automatic logic [47:0] f_partial(input logic [47:0] mcand, input logic [23:0] mplier);
        logic [47:0] acc;
        acc = 48'd0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (mplier[j]) begin
                acc = acc + (mcand << j);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    // Operand unpack: denormals are classed as zero and get a zero mantissa.
    always_comb begin
        w_sign    = dataa[31] ^ datab[31];
        w_exp_sum = $signed({2'b00, dataa[30:23]}) + $signed({2'b00, datab[30:23]}) - 10'sd127;
        w_a_zero  = (dataa[30:23] == 8'd0);
        w_b_zero  = (datab[30:23] == 8'd0);
        w_a_inf   = (dataa[30:23] == 8'hFF) && (dataa[22:0] == 23'd0);
        w_b_inf   = (datab[30:23] == 8'hFF) && (datab[22:0] == 23'd0);
        w_a_nan   = (dataa[30:23] == 8'hFF) && (dataa[22:0] != 23'd0);
        w_b_nan   = (datab[30:23] == 8'hFF) && (datab[22:0] != 23'd0);
        w_ma      = w_a_zero ? 24'd0 : {1'b1, dataa[22:0]};
        w_mb      = w_b_zero ? 24'd0 : {1'b1, datab[22:0]};
    end

    // Next-state logic: MULT runs for a fixed count, then one NORM and one PACK cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: w_state_nxt = S_IDLE;
            S_MULT: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = S_NORM;
                end else begin
                    w_state_nxt = S_MULT;
                end
            end
            S_NORM: w_state_nxt = S_PACK;
            S_PACK: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register; reset doubles as start and aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_MULT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Rounding, renormalisation, specials and range clamping for the PACK cycle.
    always_comb begin
        w_exp_fin  = r_exp;
        w_frac_fin = r_frac;
`ifdef FPMULT_SEQ_RNE_EN
        w_round_up = r_guard & (r_sticky | r_frac[0]);
        w_mant_sum = {2'b01, r_frac} + {24'd0, w_round_up};
        if (w_mant_sum[24]) begin
            w_frac_fin = w_mant_sum[23:1];
            w_exp_fin  = r_exp + 10'sd1;
        end else begin
            w_frac_fin = w_mant_sum[22:0];
            w_exp_fin  = r_exp;
        end
`endif
        if (r_nan_any || (r_inf_any && r_zero_any)) begin
            w_pack_res = 32'h7FC00000;
        end else if (r_inf_any) begin
            w_pack_res = {r_sign, 31'h7F800000};
        end else if (r_zero_any) begin
            w_pack_res = {r_sign, 31'h00000000};
        end else if (w_exp_fin >= 10'sd255) begin
            w_pack_res = {r_sign, 31'h7F800000};
        end else if (w_exp_fin <= 10'sd0) begin
            w_pack_res = {r_sign, 31'h00000000};
        end else begin
            w_pack_res = {r_sign, w_exp_fin[7:0], w_frac_fin};
        end
    end

    // Datapath: capture on start, shift-add in MULT, normalise in NORM, write result in PACK.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result   <= 32'd0;
            r_cnt      <= 5'd0;
            r_sign     <= w_sign;
            r_exp      <= w_exp_sum;
            r_mcand    <= {24'd0, w_ma};
            r_mplier   <= w_mb;
            r_prod     <= 48'd0;
            r_frac     <= 23'd0;
            r_nan_any  <= w_a_nan | w_b_nan;
            r_inf_any  <= w_a_inf | w_b_inf;
            r_zero_any <= w_a_zero | w_b_zero;
`ifdef FPMULT_SEQ_RNE_EN
            r_guard    <= 1'b0;
            r_sticky   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_MULT: begin
                    r_prod   <= r_prod + f_partial(r_mcand, r_mplier);
                    r_mcand  <= r_mcand << BITS_PER_CYCLE;
                    r_mplier <= r_mplier >> BITS_PER_CYCLE;
                    r_cnt    <= r_cnt + 5'd1;
                end
                S_NORM: begin
                    if (r_prod[47]) begin
                        r_frac   <= r_prod[46:24];
                        r_exp    <= r_exp + 10'sd1;
`ifdef FPMULT_SEQ_RNE_EN
                        r_guard  <= r_prod[23];
                        r_sticky <= |r_prod[22:0];
`endif
                    end else begin
                        r_frac   <= r_prod[45:23];
                        r_exp    <= r_exp;
`ifdef FPMULT_SEQ_RNE_EN
                        r_guard  <= r_prod[22];
                        r_sticky <= |r_prod[21:0];
`endif
                    end
                end
                S_PACK: begin
                    r_result <= w_pack_res;
                end
                default: begin
                    r_result <= r_result;
                end
            endcase
        end
    end

    assign result = r_result;
    assign done   = (r_state == S_IDLE) & ~reset;

endmodule

// File: tb/tb_fpmult_seq.sv
// Directed self-checking bench for fpmult_seq (default BITS_PER_CYCLE, latency 26).
module tb_fpmult_seq;

    logic        clk;
    logic        reset;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [31:0] result;
    logic        done;

    int n_tests;
    int n_fail;

    fpmult_seq dut (
        .clk    (clk),
        .reset  (reset),
        .dataa  (dataa),
        .datab  (datab),
        .result (result),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Holds reset for nhigh cycles; only the last high edge carries the real operands.
    task automatic do_start(input logic [31:0] a, input logic [31:0] b, input int nhigh);
        @(negedge clk);
        for (int i = 0; i < nhigh; i++) begin
            reset = 1'b1;
            dataa = (i == nhigh - 1) ? a : 32'h3F800000;
            datab = (i == nhigh - 1) ? b : 32'h3F800000;
            #1;
            check_eq("done_during_start", {31'd0, done}, 32'd0);
            @(negedge clk);
            check_eq("result_cleared", result, 32'd0);
        end
        reset = 1'b0;
        dataa = 32'hDEADBEEF;
        datab = 32'h12345678;
    endtask

    task automatic wait_done(input string tag, input logic [31:0] exp);
        int cycles;
        cycles = 0;
        while (!done && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        check_eq({tag, "_latency"}, cycles, 32'd26);
        check_eq(tag, result, exp);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        do_start(a, b, 1);
        wait_done(tag, exp);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        dataa   = 32'd0;
        datab   = 32'd0;

        run_op("two_x_three",  32'h40000000, 32'h40400000, 32'h40C00000);
        run_op("mixed_sign",   32'h3FC00000, 32'hBF000000, 32'hBF400000);
        run_op("one_x_one",    32'h3F800000, 32'h3F800000, 32'h3F800000);
        run_op("neg_x_neg",    32'hC0000000, 32'hC0000000, 32'h40800000);
        run_op("inf_x_zero",   32'h7F800000, 32'h00000000, 32'h7FC00000);
        run_op("ninf_x_two",   32'hFF800000, 32'h40000000, 32'hFF800000);
        run_op("nzero_x_one",  32'h80000000, 32'h3F800000, 32'h80000000);
        run_op("nan_in",       32'h7FC00001, 32'h3F800000, 32'h7FC00000);
        run_op("denorm_flush", 32'h00000001, 32'h40000000, 32'h00000000);
        run_op("overflow",     32'h7F7FFFFF, 32'h40000000, 32'h7F800000);
        run_op("underflow",    32'h00800000, 32'h3F000000, 32'h00000000);
`ifdef FPMULT_SEQ_RNE_EN
        run_op("tie_odd_lsb",  32'h3F800001, 32'h3FC00000, 32'h3FC00002);
`else
        run_op("tie_odd_lsb",  32'h3F800001, 32'h3FC00000, 32'h3FC00001);
`endif

        // Result must hold while idle even as operands change without reset.
        dataa = 32'h40800000;
        datab = 32'h40800000;
        repeat (5) @(negedge clk);
        check_eq("hold_done", {31'd0, done}, 32'd1);
        `ifdef FPMULT_SEQ_RNE_EN
        check_eq("hold_result", result, 32'h3FC00002);
        `else
        check_eq("hold_result", result, 32'h3FC00001);
        `endif

        // Abort at cycle 10 with a single-cycle restart pulse.
        do_start(32'h40000000, 32'h40400000, 1);
        repeat (10) @(negedge clk);
        check_eq("busy_before_abort", {31'd0, done}, 32'd0);
        do_start(32'h40800000, 32'h40800000, 1);
        wait_done("abort_pulse", 32'h41800000);

        // Abort with reset held three cycles; latency counts from the last high edge.
        do_start(32'h40000000, 32'h40400000, 1);
        repeat (10) @(negedge clk);
        check_eq("busy_before_abort3", {31'd0, done}, 32'd0);
        do_start(32'h40800000, 32'h40800000, 3);
        wait_done("abort_hold3", 32'h41800000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
